// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
// Fetch-side entries carry an instruction word together with its byte PC.
package riscv_pkg;

  localparam int          XLEN        = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push/pop/flush and an
// occupancy count. The head is read straight out of the storage registers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head,
  output logic                   head_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // NOTE: the storage is only DEPTH entries, so it is reset too; that keeps
  // the head (and thus instr_data/instr_pc) at zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      // A pop in the flush cycle is simply absorbed by emptying everything.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the synchronous instruction ROM and
// hands instructions to decode over valid/ready, flushing on redirects.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          D_WIDTH    = 32,
  parameter int          MEM_DEPTH  = 1024,
  parameter int          A_WIDTH    = $clog2(MEM_DEPTH),
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_enable,
  output logic                        rom_en,
  output logic [A_WIDTH-1:0]          rom_addr,
  input  logic [D_WIDTH-1:0]          rom_data,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [D_WIDTH-1:0]          instr_data,
  output logic [31:0]                 instr_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state_q;
  fetch_state_t   state;
  logic [31:0]    pc;
  logic [31:0]    inflight_pc;
  logic           inflight;
  logic           rsp_valid;
  logic           pop;
  logic           fifo_push;
  logic           fifo_pop;
  logic           head_valid;
  logic [CNT_W:0] pending;
  fetch_entry_t   rsp_entry;
  fetch_entry_t   head;

  // REDIR is the cycle in which the redirect is seen, so it is derived
  // combinationally and never held in the state register.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state = state_q;
    if (redirect_valid && state_q == RUN) state = REDIR;
  end

  // A response arriving in a redirect cycle belongs to the old stream.
  assign rsp_valid = inflight && !redirect_valid;
  assign rsp_entry = '{data: rom_data, pc: inflight_pc};

  // An empty buffer lets the landing response go straight to decode, which
  // gives one-cycle issue-to-valid latency.
  assign instr_valid = head_valid || rsp_valid;
  assign pop         = instr_valid && instr_ready;
  assign fifo_pop    = head_valid && instr_ready;
  assign fifo_push   = rsp_valid && (head_valid || !instr_ready);

  always_comb begin
    instr_data = head.data;
    instr_pc   = head.pc;
    if (!head_valid && rsp_valid) begin
      instr_data = rom_data;
      instr_pc   = inflight_pc;
    end
  end

  // Reserve a slot for the response before issuing, so none is ever dropped.
  assign pending  = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign rom_en   = (state == RUN) && fetch_enable
                    && (pending < (CNT_W+1)'(FIFO_DEPTH));
  assign rom_addr = pc[A_WIDTH+1:2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      unique case (state)
        BOOT:    state_q <= RUN;
        RUN:     state_q <= RUN;
        REDIR:   state_q <= RUN;
        default: state_q <= BOOT;
      endcase
      inflight <= rom_en;
      if (rom_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'(INSTR_BYTES);
      end
      if (redirect_valid) pc <= redirect_pc & ~32'(INSTR_BYTES - 1);
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (rsp_entry),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head       (head),
    .head_valid (head_valid)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous ROM model whose
// word k holds 32'hA000_0000 + k.
module tb_instr_fetch_unit;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        fetch_enable   = 1'b1;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data       = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_valid;
  logic        instr_ready    = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable   (fetch_enable),
    .rom_en         (rom_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= 32'hA000_0000 + 32'(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"},    instr_pc, pc);
    check({tag, "_data"},  instr_data, 32'hA000_0000 + ((pc >> 2) & 32'h3FF));
  endtask

  initial begin
    repeat (2) tick();
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);

    // Boot and streaming at one instruction per cycle.
    rst_n = 1'b1;
    tick();
    check("boot_rom_en", 32'(rom_en), 32'd1);
    check("boot_rom_addr", 32'(rom_addr), 32'd0);
    check("boot_valid", 32'(instr_valid), 32'd0);
    tick();
    check_head("first", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_head("stream", 32'(4 * k));
    end

    // Backpressure: head held, buffer fills, issue stops.
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_head("stall", 32'd20);
      check("stall_rom_en", 32'(rom_en), 32'd0);
    end
    check("stall_count", 32'(fifo_count), 32'd2);
    instr_ready = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      tick();
      check_head("resume", 32'(4 * k));
    end
    check("resume_count", 32'(fifo_count), 32'd1);

    // Redirect with a buffered entry and a fetch in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("redir_rom_en", 32'(rom_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_t1_rom_en", 32'(rom_en), 32'd1);
    check("redir_t1_addr", 32'(rom_addr), 32'd64);
    check("redir_t1_valid", 32'(instr_valid), 32'd0);
    check("redir_t1_count", 32'(fifo_count), 32'd0);
    tick();
    check_head("redir_t2", 32'h100);
    tick();
    check_head("redir_t3", 32'h104);

    // Word-address wrap at the top of the ROM.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr_hi", 32'(rom_addr), 32'd1023);
    check("wrap_rom_en", 32'(rom_en), 32'd1);
    tick();
    check("wrap_addr_lo", 32'(rom_addr), 32'd0);
    check_head("wrap_ffc", 32'hFFC);
    tick();
    check_head("wrap_1000", 32'h1000);
    check("wrap_addr_next", 32'(rom_addr), 32'd1);

    // Halt issue while the 0x1000 response is landing; it is still delivered.
    fetch_enable = 1'b0;
    #1;
    check("halt_rom_en", 32'(rom_en), 32'd0);
    check_head("halt_deliver", 32'h1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_idle_valid", 32'(instr_valid), 32'd0);
      check("halt_idle_rom_en", 32'(rom_en), 32'd0);
    end
    fetch_enable = 1'b1;
    #1;
    check("reen_rom_en", 32'(rom_en), 32'd1);
    check("reen_addr", 32'(rom_addr), 32'd1);
    tick();
    check_head("reen_1004", 32'h1004);
    tick();
    check_head("reen_1008", 32'h1008);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_pc", instr_pc, 32'd0);
    check("mid_rst_data", instr_data, 32'd0);
    check("mid_rst_rom_en", 32'(rom_en), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("reboot_rom_en", 32'(rom_en), 32'd1);
    check("reboot_addr", 32'(rom_addr), 32'd0);
    check("reboot_valid", 32'(instr_valid), 32'd0);
    tick();
    check_head("reboot_first", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
